airlock_controller: RTL and testbench
=====================================

Name: airlock_controller

Overview:
- Parametrised successor to the two-FSM airlock interlock: one FSM serves both arrivals and departures.
- Drives the outer door, the inner door and the chamber pressure, with configurable evacuate/pressurise durations.
- Counts seconds with an internal prescaler. Supports aborting and reversing a transit mid-cycle, and flags rejected commands.
- Sits below the board top level. All inputs arrive already synchronised and debounced on `clock`.

Parameters:
- TICK_DIV, 50, `clock` cycles per one-second tick; must be ≥ 2.
- PRESS_SECS, 5, seconds needed to pressurise the chamber; must be ≥ 1.
- EVAC_SECS, 8, seconds needed to evacuate the chamber; must be ≥ 1.
- CNT_W, 4, width of the seconds counter; must hold max(PRESS_SECS, EVAC_SECS).

Ports:
- clock  in  1  system clock; all logic runs on its rising edge.
- reset  in  1  synchronous reset, active-high.
- outer_req  in  1  level: request outer door open.
- inner_req  in  1  level: request inner door open.
- press_req  in  1  one-cycle pulse: pressurise the chamber.
- evac_req  in  1  one-cycle pulse: evacuate the chamber.
- outer_open  out  1  outer door open.
- inner_open  out  1  inner door open.
- pressurized  out  1  chamber at full pressure with no transit in progress.
- evacuated  out  1  chamber at vacuum with no transit in progress.
- busy  out  1  evacuation or pressurisation in progress.
- seconds  out  CNT_W  whole seconds elapsed in the current transit.
- reject  out  1  one-cycle pulse: a press_req or evac_req was refused.
- state  out  3  FSM state encoding, for debug.

Behaviour:
- States and encodings: PRESSED=0, INNER_OPEN=1, EVACUATING=2, EVACUATED=3, OUTER_OPEN=4, PRESSURIZING=5. Codes 6 and 7 recover to PRESSED on the next cycle.
- All outputs are registered. Every response appears one cycle after the input is sampled.
- Reset (synchronous, overrides everything, including mid-transit):
  - state=PRESSED, pressurized=1, all other outputs 0.
  - Prescaler and seconds cleared.
- Output decode:
  - inner_open=1 only in INNER_OPEN; outer_open=1 only in OUTER_OPEN. The two are never high together.
  - pressurized=1 in PRESSED and INNER_OPEN; evacuated=1 in EVACUATED and OUTER_OPEN.
  - busy=1 in EVACUATING and PRESSURIZING.
- PRESSED:
  - inner_req=1 → INNER_OPEN.
  - evac_req with inner_req=0 and outer_req=0 → EVACUATING.
  - evac_req otherwise → reject. Any press_req → reject.
  - outer_req is held off: no state change, no reject.
- INNER_OPEN: inner_req=0 → PRESSED. Any press_req or evac_req → reject.
- EVACUATED / OUTER_OPEN: mirror images of PRESSED / INNER_OPEN, using outer_req and press_req → PRESSURIZING.
- Transit timing (EVACUATING, PRESSURIZING):
  - On entry, prescaler and seconds clear to 0.
  - Prescaler counts 0..TICK_DIV-1 and wraps. Each wrap is a tick and increments seconds.
  - On the tick where seconds == DUR-1 (DUR is EVAC_SECS or PRESS_SECS), go to EVACUATED or PRESSURIZED respectively.
  - Rest state is therefore reached exactly DUR*TICK_DIV cycles after entering the transit state.
  - seconds reads 0 in all rest states.
- Abort:
  - press_req during EVACUATING → PRESSURIZING; seconds and prescaler restart at 0 and the full PRESS_SECS applies.
  - evac_req during PRESSURIZING → EVACUATING, likewise with the full EVAC_SECS.
  - Same-direction request during a transit (e.g. evac_req in EVACUATING) → reject, timing unaffected.
- Door requests during a transit are held off; doors stay closed.
- press_req and evac_req in the same cycle → reject in every state, no state change.
- Counter width: seconds never exceeds max(PRESS_SECS, EVAC_SECS), so there is no wrap at CNT_W.

Optional Feature:
- Macro: AIRLOCK_HEX_EN.
- Defined:
  - Adds output hex_secs[6:0]: active-low seven-segment encoding of seconds, hex digits 0–F, registered alongside seconds.
  - Shows blank (7'b1111111) whenever busy=0.
  - Adds output hex_dir[6:0]: displays "E" during EVACUATING, "P" during PRESSURIZING, blank otherwise.
- Undefined: both ports and their logic are absent; all other behaviour is identical.

Test Plan:
(Parameters for all scenarios: TICK_DIV=4, PRESS_SECS=5, EVAC_SECS=8.)
1. Reset held 2 cycles → state=0, pressurized=1, doors=0, busy=0, seconds=0, reject=0.
2. Full arrival cycle:
   - evac_req pulse → busy=1 next cycle; seconds steps 1..7 every 4 cycles; evacuated=1 exactly 32 cycles after entering EVACUATING.
   - outer_req=1 → outer_open=1 next cycle; outer_req=0 → outer_open=0.
   - press_req → pressurized=1 after 20 cycles.
   - inner_req=1 → inner_open=1.
3. Interlock checks:
   - In PRESSED with outer_req=1 for 10 cycles → outer_open stays 0, no reject.
   - evac_req with inner_req=1 → reject=1 for one cycle, state stays INNER_OPEN.
4. Abort: evac_req, then press_req when seconds=3 → state=5, seconds=0; pressurized=1 after 20 more cycles.
5. press_req and evac_req in the same cycle during PRESSURIZING → reject pulse; completion time unchanged.
   - Also: inner_req=1 during PRESSURIZING → inner_open=0 until PRESSED.
6. reset asserted while seconds=5 in EVACUATING → next cycle state=PRESSED, pressurized=1, seconds=0, busy=0.

Source files
------------

// File: rtl/airlock_controller.sv
// airlock_controller: single-FSM airlock interlock driving both doors and chamber pressure.
// Ports:
//   clock_i, reset_i        rising-edge clock and synchronous active-high reset
//   outer_req_i/inner_req_i level door-open requests
//   press_req_i/evac_req_i  one-cycle pressurise / evacuate commands
//   outer_open_o/inner_open_o door drives (never both high)
//   pressurized_o/evacuated_o chamber at rest at full pressure / vacuum
//   busy_o                  transit (evacuation or pressurisation) in progress
//   seconds_o               whole seconds elapsed in the current transit
//   reject_o                one-cycle pulse when a press/evac command is refused
//   state_o                 FSM state code for debug
// Optional macro AIRLOCK_HEX_EN adds hex_secs_o (active-low 7-seg of seconds,
// blank when idle) and hex_dir_o ("E"/"P" during evacuate/pressurise, else blank).
module airlock_controller #(
    parameter int TICK_DIV   = 50,
    parameter int PRESS_SECS = 5,
    parameter int EVAC_SECS  = 8,
    parameter int CNT_W      = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             outer_req_i,
    input  logic             inner_req_i,
    input  logic             press_req_i,
    input  logic             evac_req_i,
    output logic             outer_open_o,
    output logic             inner_open_o,
    output logic             pressurized_o,
    output logic             evacuated_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] seconds_o,
    output logic             reject_o,
`ifdef AIRLOCK_HEX_EN
    output logic [6:0]       hex_secs_o,
    output logic [6:0]       hex_dir_o,
`endif
    output logic [2:0]       state_o
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] EVAC_LAST = CNT_W'(EVAC_SECS - 1);
    localparam logic [CNT_W-1:0] PRESS_LAST = CNT_W'(PRESS_SECS - 1);

    typedef enum logic [2:0] {
        PRESSED      = 3'd0,
        INNER_OPEN   = 3'd1,
        EVACUATING   = 3'd2,
        EVACUATED    = 3'd3,
        OUTER_OPEN   = 3'd4,
        PRESSURIZING = 3'd5
    } state_e;

    state_e           state_q, state_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic [CNT_W-1:0] secs_q, secs_d;
    logic             rej_q, rej_d;
    logic             both, tick;

    // Simultaneous press and evac is always refused and never moves the FSM.
    assign both = press_req_i & evac_req_i;
    assign tick = presc_q == PRESC_LAST;

    always_comb begin
        state_d = state_q;
        presc_d = '0;
        secs_d  = '0;
        rej_d   = 1'b0;
        case (state_q)
            PRESSED: begin
                rej_d = press_req_i | (evac_req_i & (inner_req_i | outer_req_i));
                if (!both)
                    state_d = inner_req_i ? INNER_OPEN :
                              (evac_req_i && !outer_req_i) ? EVACUATING : PRESSED;
            end
            INNER_OPEN: begin
                rej_d = press_req_i | evac_req_i;
                if (!both && !inner_req_i) state_d = PRESSED;
            end
            EVACUATED: begin
                rej_d = evac_req_i | (press_req_i & (inner_req_i | outer_req_i));
                if (!both)
                    state_d = outer_req_i ? OUTER_OPEN :
                              (press_req_i && !inner_req_i) ? PRESSURIZING : EVACUATED;
            end
            OUTER_OPEN: begin
                rej_d = press_req_i | evac_req_i;
                if (!both && !outer_req_i) state_d = EVACUATED;
            end
            EVACUATING: begin
                rej_d = evac_req_i;
                // An abort leaves presc_d/secs_d at their zero defaults so the new transit restarts.
                if (press_req_i && !evac_req_i) state_d = PRESSURIZING;
                else if (tick && secs_q == EVAC_LAST) state_d = EVACUATED;
                else begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    secs_d  = secs_q + CNT_W'(tick);
                end
            end
            PRESSURIZING: begin
                rej_d = press_req_i;
                if (evac_req_i && !press_req_i) state_d = EVACUATING;
                else if (tick && secs_q == PRESS_LAST) state_d = PRESSED;
                else begin
                    presc_d = tick ? '0 : presc_q + PW'(1);
                    secs_d  = secs_q + CNT_W'(tick);
                end
            end
            default: state_d = PRESSED;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= PRESSED;
            presc_q <= '0;
            secs_q  <= '0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            secs_q  <= secs_d;
            rej_q   <= rej_d;
        end
    end

    assign state_o       = state_q;
    assign outer_open_o  = state_q == OUTER_OPEN;
    assign inner_open_o  = state_q == INNER_OPEN;
    assign pressurized_o = state_q == PRESSED || state_q == INNER_OPEN;
    assign evacuated_o   = state_q == EVACUATED || state_q == OUTER_OPEN;
    assign busy_o        = state_q == EVACUATING || state_q == PRESSURIZING;
    assign seconds_o     = secs_q;
    assign reject_o      = rej_q;

`ifdef AIRLOCK_HEX_EN
    logic [6:0] hex_secs_q, hex_dir_q;

    // Segment order {g,f,e,d,c,b,a}, a 0 lights the segment.
    function automatic logic [6:0] seg(input logic [3:0] v);
        case (v)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            default: seg = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            hex_secs_q <= 7'h7F;
            hex_dir_q  <= 7'h7F;
        end else begin
            hex_secs_q <= (state_d == EVACUATING || state_d == PRESSURIZING) ? seg(4'(secs_d)) : 7'h7F;
            hex_dir_q  <= state_d == EVACUATING ? 7'h06 : state_d == PRESSURIZING ? 7'h0C : 7'h7F;
        end
    end

    assign hex_secs_o = hex_secs_q;
    assign hex_dir_o  = hex_dir_q;
`endif
endmodule

// File: tb/tb_airlock_controller.sv
// tb_airlock_controller: vector table, directed sequences and randomized run against a cycle-count model.
module tb_airlock_controller;
    localparam int TD = 4;
    localparam int PS = 5;
    localparam int ES = 8;

    logic clock = 1'b0;
    logic reset, outer_req, inner_req, press_req, evac_req;
    logic outer_open, inner_open, pressurized, evacuated, busy, reject;
    logic [3:0] seconds;
    logic [2:0] state;

    airlock_controller #(.TICK_DIV(TD), .PRESS_SECS(PS), .EVAC_SECS(ES), .CNT_W(4)) dut (
        .clock_i(clock), .reset_i(reset),
        .outer_req_i(outer_req), .inner_req_i(inner_req),
        .press_req_i(press_req), .evac_req_i(evac_req),
        .outer_open_o(outer_open), .inner_open_o(inner_open),
        .pressurized_o(pressurized), .evacuated_o(evacuated),
        .busy_o(busy), .seconds_o(seconds), .reject_o(reject), .state_o(state)
    );

    always #5 clock = ~clock;

    int vecs = 0;
    int errs = 0;
    int cyc_n = 0;

    // Model: location code plus cycles elapsed since the transit began.
    int m_st = 0;
    int m_el = 0;
    logic m_rej = 1'b0;

    function automatic logic [13:0] act_vec();
        return {state, outer_open, inner_open, pressurized, evacuated, busy, seconds, reject};
    endfunction

    function automatic logic [13:0] exp_vec();
        logic tr;
        tr = (m_st == 2 || m_st == 5);
        return {3'(m_st), m_st == 4, m_st == 1, m_st <= 1, m_st == 3 || m_st == 4, tr,
                tr ? 4'(m_el / TD) : 4'd0, m_rej};
    endfunction

    task automatic model_step(input logic r, o, i, p, e);
        if (r) begin
            m_st = 0; m_el = 0; m_rej = 0;
            return;
        end
        case (m_st)
            0: begin
                m_rej = p | (e & (i | o));
                if (!(p && e)) begin
                    if (i) m_st = 1;
                    else if (e && !o) begin m_st = 2; m_el = 0; end
                end
            end
            1: begin
                m_rej = p | e;
                if (!(p && e) && !i) m_st = 0;
            end
            3: begin
                m_rej = e | (p & (i | o));
                if (!(p && e)) begin
                    if (o) m_st = 4;
                    else if (p && !i) begin m_st = 5; m_el = 0; end
                end
            end
            4: begin
                m_rej = p | e;
                if (!(p && e) && !o) m_st = 3;
            end
            2: begin
                m_rej = e;
                if (p && !e) begin m_st = 5; m_el = 0; end
                else begin
                    m_el++;
                    if (m_el == ES * TD) begin m_st = 3; m_el = 0; end
                end
            end
            default: begin
                m_rej = p;
                if (e && !p) begin m_st = 2; m_el = 0; end
                else begin
                    m_el++;
                    if (m_el == PS * TD) begin m_st = 0; m_el = 0; end
                end
            end
        endcase
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc_n, act, exp);
        end
    endtask

    task automatic cyc(input logic r, o, i, p, e);
        reset = r; outer_req = o; inner_req = i; press_req = p; evac_req = e;
        @(posedge clock);
        #1;
        cyc_n++;
        model_step(r, o, i, p, e);
        chk("model", 32'(act_vec()), 32'(exp_vec()));
    endtask

    typedef struct {
        logic r, o, i, p, e;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[19];

    function automatic vec_t mk(input logic r, o, i, p, e, input logic [2:0] st,
                                input logic [3:0] sec, input logic rej);
        vec_t v;
        v.r = r; v.o = o; v.i = i; v.p = p; v.e = e;
        v.exp = {st, st == 3'd4, st == 3'd1, st <= 3'd1, st == 3'd3 || st == 3'd4,
                 st == 3'd2 || st == 3'd5, sec, rej};
        return v;
    endfunction

    int done_k;

    initial begin
        reset = 1; outer_req = 0; inner_req = 0; press_req = 0; evac_req = 0;
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 0, 0, 0, 0, 0);
        tbl[3]  = mk(0, 1, 0, 0, 0, 0, 0, 0);
        tbl[4]  = mk(0, 0, 1, 0, 0, 1, 0, 0);
        tbl[5]  = mk(0, 0, 1, 0, 1, 1, 0, 1);
        tbl[6]  = mk(0, 0, 1, 0, 0, 1, 0, 0);
        tbl[7]  = mk(0, 0, 1, 1, 0, 1, 0, 1);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[9]  = mk(0, 0, 0, 1, 0, 0, 0, 1);
        tbl[10] = mk(0, 0, 0, 1, 1, 0, 0, 1);
        tbl[11] = mk(0, 1, 0, 0, 1, 0, 0, 1);
        tbl[12] = mk(0, 0, 0, 0, 1, 2, 0, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 2, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 1, 2, 0, 1);
        tbl[15] = mk(0, 0, 0, 0, 0, 2, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 2, 1, 0);
        tbl[17] = mk(0, 0, 0, 1, 0, 5, 0, 0);
        tbl[18] = mk(1, 0, 0, 0, 0, 0, 0, 0);
        for (int n = 0; n < 19; n++) begin
            cyc(tbl[n].r, tbl[n].o, tbl[n].i, tbl[n].p, tbl[n].e);
            chk($sformatf("table[%0d]", n), 32'(act_vec()), 32'(tbl[n].exp));
        end

        // Full arrival cycle.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1);
        chk("evac_busy", busy, 1);
        done_k = -1;
        for (int k = 1; k <= 40 && done_k < 0; k++) begin
            cyc(0, 0, 0, 0, 0);
            if (k % 4 == 0 && k < 32) chk("evac_secs", seconds, k / 4);
            if (evacuated) done_k = k;
        end
        chk("evac_time", done_k, 32);
        cyc(0, 1, 0, 0, 0);
        chk("outer_open", outer_open, 1);
        cyc(0, 0, 0, 0, 0);
        chk("outer_close", outer_open, 0);
        cyc(0, 0, 0, 1, 0);
        done_k = -1;
        for (int k = 1; k <= 30 && done_k < 0; k++) begin
            cyc(0, 0, 0, 0, 0);
            if (pressurized) done_k = k;
        end
        chk("press_time", done_k, 20);
        cyc(0, 0, 1, 0, 0);
        chk("inner_open", inner_open, 1);

        // Interlocks.
        cyc(0, 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            cyc(0, 1, 0, 0, 0);
            chk("outer_held_off", {outer_open, reject}, 0);
        end
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 1);
        chk("inner_evac_reject", {state, reject}, {3'd1, 1'b1});
        cyc(0, 0, 1, 0, 0);
        chk("reject_one_cycle", reject, 0);
        cyc(0, 0, 0, 0, 0);

        // Abort at seconds == 3.
        cyc(0, 0, 0, 0, 1);
        for (int k = 0; k < 40 && seconds != 3; k++) cyc(0, 0, 0, 0, 0);
        chk("abort_reach3", seconds, 3);
        cyc(0, 0, 0, 1, 0);
        chk("abort_state", {state, seconds}, {3'd5, 4'd0});
        done_k = -1;
        for (int k = 1; k <= 30 && done_k < 0; k++) begin
            cyc(0, 0, 0, 0, 0);
            if (pressurized) done_k = k;
        end
        chk("abort_press_time", done_k, 20);

        // Both commands during pressurising, and inner door held off.
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 1, 1);
        chk("both_reject", {state, reject}, {3'd5, 1'b1});
        done_k = -1;
        for (int k = 4; k <= 30 && done_k < 0; k++) begin
            cyc(0, 0, 1, 0, 0);
            if (pressurized) done_k = k;
            else chk("inner_held", inner_open, 0);
        end
        chk("both_press_time", done_k, 20);
        cyc(0, 0, 1, 0, 0);
        chk("inner_after", inner_open, 1);
        cyc(0, 0, 0, 0, 0);

        // Reset mid-evacuation.
        cyc(0, 0, 0, 0, 1);
        for (int k = 0; k < 40 && seconds != 5; k++) cyc(0, 0, 0, 0, 0);
        chk("reach5", seconds, 5);
        cyc(1, 0, 0, 0, 0);
        chk("mid_reset", 32'(act_vec()), 32'(14'b000_0_0_1_0_0_0000_0));

        // Randomized run against the model.
        cyc(1, 0, 0, 0, 0);
        begin
            logic o, i;
            o = 0; i = 0;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(15) == 0) o = ~o;
                if ($urandom_range(15) == 0) i = ~i;
                cyc($urandom_range(499) == 0, o, i,
                    $urandom_range(23) == 0, $urandom_range(23) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
